// File: rtl/qed_pair_scan_checker.sv
// qed_pair_scan_checker: counts original/duplicate commits, scans reg[k] vs reg[k+NREGS/2] when counts match, reports pass or lowest failing pair.
module qed_pair_scan_checker #(
  parameter int NREGS = 32,
  parameter int WIDTH = 72,
  parameter int COMPARE_LANES = 4,
  parameter int CNT_W = 8,
  localparam int HALF = NREGS / 2,
  localparam int IDX_W = (HALF > 1) ? $clog2(HALF) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   ena,
  input  logic                   check_mode,
  input  logic                   orig_commit,
  input  logic                   dup_commit,
  input  logic [NREGS*WIDTH-1:0] regs_flat,
  input  logic                   clear,
  output logic                   qed_ready,
  output logic                   check_busy,
  output logic                   check_done,
  output logic                   mismatch,
  output logic [IDX_W-1:0]       mismatch_idx,
  output logic [CNT_W-1:0]       orig_cnt,
  output logic [CNT_W-1:0]       dup_cnt,
  output logic                   cnt_ovf
);
  localparam int S = HALF / COMPARE_LANES;
  localparam int GW = (S > 1) ? $clog2(S) : 1;
  localparam logic [CNT_W-1:0] MAX = '1;
  typedef enum logic [1:0] {IDLE, SCAN, DONE, ERR} state_t;
  state_t state, state_nxt;
  logic [GW-1:0] grp;
  logic dirty, o_inc, d_inc, abort, last, any_neq;
  logic [CNT_W-1:0] orig_nxt, dup_nxt;
  logic [COMPARE_LANES-1:0] neq;
  logic [IDX_W-1:0] first_idx;
  assign o_inc = ena & orig_commit;
  assign d_inc = ena & dup_commit;
  assign orig_nxt = (o_inc && orig_cnt != MAX) ? orig_cnt + CNT_W'(1) : orig_cnt;
  assign dup_nxt = (d_inc && dup_cnt != MAX) ? dup_cnt + CNT_W'(1) : dup_cnt;
  assign qed_ready = ena & check_mode & (state == IDLE) & dirty & ~cnt_ovf
                   & (orig_cnt == dup_cnt) & ~orig_commit & ~dup_commit;
  assign check_busy = state == SCAN;
  assign check_done = state == DONE;
  assign abort = orig_commit | dup_commit | ~check_mode | ~ena;
  assign last = grp == GW'(S - 1);
  assign any_neq = |neq;
  always_comb begin
    neq = '0;
    first_idx = '0;
    for (int l = COMPARE_LANES - 1; l >= 0; l--) begin
      neq[l] = regs_flat[(int'(grp) * COMPARE_LANES + l) * WIDTH +: WIDTH]
            != regs_flat[(int'(grp) * COMPARE_LANES + l + HALF) * WIDTH +: WIDTH];
      first_idx = neq[l] ? IDX_W'(int'(grp) * COMPARE_LANES + l) : first_idx;
    end
  end
  always_comb begin
    state_nxt = (state == IDLE) ? (qed_ready ? SCAN : IDLE)
              : (state == SCAN) ? (abort ? IDLE : any_neq ? ERR : last ? DONE : SCAN)
              : (state == DONE) ? IDLE : ERR;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      grp <= '0;
      dirty <= 1'b0;
      orig_cnt <= '0;
      dup_cnt <= '0;
      cnt_ovf <= 1'b0;
      mismatch <= 1'b0;
      mismatch_idx <= '0;
    end else if (clear) begin
      state <= IDLE;
      grp <= '0;
      dirty <= 1'b0;
      orig_cnt <= '0;
      dup_cnt <= '0;
      cnt_ovf <= 1'b0;
      mismatch <= 1'b0;
      mismatch_idx <= '0;
    end else begin
      state <= state_nxt;
      grp <= (state == SCAN && state_nxt == SCAN) ? grp + GW'(1) : '0;
      dirty <= qed_ready ? 1'b0 : (dirty | o_inc | d_inc);
      orig_cnt <= orig_nxt;
      dup_cnt <= dup_nxt;
      cnt_ovf <= cnt_ovf | (orig_nxt == MAX) | (dup_nxt == MAX);
      if (state == SCAN && !abort && any_neq) begin
        mismatch <= 1'b1;
        mismatch_idx <= first_idx;
      end
    end
  end
endmodule

// File: tb/tb_qed_pair_scan_checker.sv
// tb_qed_pair_scan_checker: scoreboard bench with a cycle-level reference model of the pair scan checker.
module tb_qed_pair_scan_checker;
  localparam int NREGS = 32;
  localparam int WIDTH = 72;
  localparam int L = 4;
  localparam int CNT_W = 4;
  localparam int H = NREGS / 2;
  localparam int S = H / L;
  localparam int MAX = (1 << CNT_W) - 1;
  logic clk = 0, rst = 1, ena = 0, check_mode = 0, orig_commit = 0, dup_commit = 0, clear = 0;
  logic [NREGS*WIDTH-1:0] regs_flat = '0;
  logic qed_ready, check_busy, check_done, mismatch, cnt_ovf;
  logic [3:0] mismatch_idx;
  logic [CNT_W-1:0] orig_cnt, dup_cnt;
  logic [WIDTH-1:0] regs [NREGS];
  typedef struct {
    logic rdy, busy, done, mis, ovf;
    int idx, oc, dc;
  } exp_t;
  exp_t q[$];
  int ncmp = 0, nerr = 0;
  int m_oc, m_dc, m_age, m_idx;
  bit m_ovf, m_dirty, m_done, m_err;
  qed_pair_scan_checker #(.NREGS(NREGS), .WIDTH(WIDTH), .COMPARE_LANES(L), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .ena(ena), .check_mode(check_mode), .orig_commit(orig_commit),
    .dup_commit(dup_commit), .regs_flat(regs_flat), .clear(clear), .qed_ready(qed_ready),
    .check_busy(check_busy), .check_done(check_done), .mismatch(mismatch),
    .mismatch_idx(mismatch_idx), .orig_cnt(orig_cnt), .dup_cnt(dup_cnt), .cnt_ovf(cnt_ovf)
  );
  always #5 clk = ~clk;
  task automatic chk(input string n, input int a, input int e);
    ncmp++;
    if (a != e) begin
      nerr++;
      $display("FAIL %s at %0t: got %0d expected %0d", n, $time, a, e);
    end
  endtask
  task automatic eq_regs();
    for (int k = 0; k < H; k++) begin
      regs[k] = WIDTH'({$urandom, $urandom, $urandom});
      regs[k + H] = regs[k];
    end
  endtask
  task automatic model_reset();
    m_oc = 0; m_dc = 0; m_age = -1; m_idx = 0;
    m_ovf = 0; m_dirty = 0; m_done = 0; m_err = 0;
  endtask
  task automatic cyc(input bit o, input bit d, input bit cm, input bit en, input bit cl, input bit r);
    exp_t e;
    bit found;
    @(posedge clk);
    #1;
    rst = r; orig_commit = o; dup_commit = d; check_mode = cm; ena = en; clear = cl;
    for (int k = 0; k < NREGS; k++) regs_flat[k*WIDTH +: WIDTH] = regs[k];
    if (r) model_reset();
    e.rdy = en && cm && m_age < 0 && !m_done && !m_err && m_dirty && !m_ovf && m_oc == m_dc && !o && !d;
    e.busy = m_age >= 0; e.done = m_done; e.mis = m_err; e.idx = m_idx;
    e.oc = m_oc; e.dc = m_dc; e.ovf = m_ovf;
    q.push_back(e);
    if (r) return;
    if (cl) begin
      model_reset();
      return;
    end
    if (m_done) m_done = 0;
    else if (m_age >= 0) begin
      if (!en || !cm || o || d) m_age = -1;
      else begin
        found = 0;
        for (int k = m_age * L; k < m_age * L + L; k++)
          if (!found && regs[k] !== regs[k + H]) begin
            found = 1;
            m_idx = k;
          end
        if (found) begin
          m_err = 1;
          m_age = -1;
        end else if (m_age == S - 1) begin
          m_done = 1;
          m_age = -1;
        end else m_age++;
      end
    end else if (e.rdy) m_age = 0;
    if (e.rdy) m_dirty = 0;
    if (en && (o || d)) m_dirty = 1;
    if (en && o && m_oc < MAX) m_oc++;
    if (en && d && m_dc < MAX) m_dc++;
    if (m_oc == MAX || m_dc == MAX) m_ovf = 1;
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 1, 1, 0, 0);
  endtask
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("qed_ready", qed_ready, e.rdy);
        chk("check_busy", check_busy, e.busy);
        chk("check_done", check_done, e.done);
        chk("mismatch", mismatch, e.mis);
        if (e.mis) chk("mismatch_idx", mismatch_idx, e.idx);
        chk("orig_cnt", orig_cnt, e.oc);
        chk("dup_cnt", dup_cnt, e.dc);
        chk("cnt_ovf", cnt_ovf, e.ovf);
      end
    end
  end
  initial begin
    int nb, at;
    model_reset();
    eq_regs();
    cyc(0, 0, 1, 1, 0, 1);
    cyc(0, 0, 1, 1, 0, 1);
    repeat (3) cyc(1, 1, 1, 1, 0, 0);
    idle(1);
    #1 chk("t1_ready", qed_ready, 1);
    nb = 0; at = 0;
    for (int i = 1; i <= 6; i++) begin
      idle(1);
      #1;
      if (check_busy) nb++;
      if (check_done) at = i;
    end
    chk("t1_busy_cycles", nb, 4);
    chk("t1_done_at", at, 5);
    regs[21] = regs[21] ^ 72'h1;
    cyc(1, 1, 1, 1, 0, 0);
    idle(1);
    #1 chk("t2_ready", qed_ready, 1);
    at = 0; nb = 0;
    for (int i = 1; i <= 6; i++) begin
      idle(1);
      #1;
      if (mismatch && at == 0) at = i;
      if (check_done) nb++;
    end
    chk("t2_mis_at", at, 3);
    chk("t2_idx", mismatch_idx, 5);
    chk("t2_no_done", nb, 0);
    cyc(1, 1, 1, 1, 0, 0);
    idle(3);
    #1 chk("t2_held_err", mismatch, 1);
    cyc(0, 0, 1, 1, 1, 0);
    regs[21] = regs[5];
    idle(1);
    #1 chk("t2_cleared", mismatch, 0);
    cyc(1, 1, 1, 1, 0, 0);
    idle(2);
    cyc(1, 0, 1, 1, 0, 0);
    idle(4);
    #1 chk("t3_aborted_busy", check_busy, 0);
    chk("t3_aborted_mis", mismatch, 0);
    cyc(0, 1, 1, 1, 0, 0);
    idle(1);
    #1 chk("t3_rescan_ready", qed_ready, 1);
    idle(5);
    #1 chk("t3_rescan_done", check_done, 1);
    cyc(0, 0, 1, 1, 1, 0);
    repeat (3) cyc(1, 1, 1, 1, 0, 0);
    cyc(1, 0, 1, 1, 0, 0);
    idle(1);
    #1 chk("t4_unequal_ready", qed_ready, 0);
    cyc(0, 1, 1, 1, 0, 0);
    idle(1);
    #1 chk("t4_equal_ready", qed_ready, 1);
    idle(6);
    cyc(0, 0, 1, 1, 1, 0);
    repeat (MAX + 2) cyc(1, 1, 1, 1, 0, 0);
    idle(1);
    #1 chk("t5_sat_cnt", orig_cnt, MAX);
    chk("t5_ovf", cnt_ovf, 1);
    chk("t5_ready", qed_ready, 0);
    cyc(0, 0, 1, 1, 1, 0);
    idle(1);
    #1 chk("t5_clear_cnt", orig_cnt, 0);
    cyc(1, 1, 1, 1, 0, 0);
    idle(3);
    #1 chk("t6_busy_before", check_busy, 1);
    cyc(0, 0, 1, 1, 0, 1);
    #1 chk("t6_busy_rst", check_busy, 0);
    chk("t6_cnt_rst", orig_cnt, 0);
    idle(2);
    #1 chk("t6_no_dirty", qed_ready, 0);
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(7) == 0) eq_regs();
      if ($urandom_range(39) == 0) regs[$urandom_range(NREGS - 1)][$urandom_range(WIDTH - 1)] ^= 1'b1;
      cyc($urandom_range(5) == 0, $urandom_range(5) == 0, $urandom_range(15) != 0,
          $urandom_range(31) != 0, $urandom_range(63) == 0, $urandom_range(499) == 0);
    end
    idle(2);
    for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
    @(posedge clk);
    if (q.size() != 0) chk("scoreboard_drain", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule
